// File: rtl/ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram_ctrl_pkg
// Shared definitions for the two-requester single-port RAM arbiter:
//   - default data width, RAM depth and burst limit
//   - arbiter FSM state encoding (IDLE, OWN0, OWN1)
// ---------------------------------------------------------------------------
package ram_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 16;
   localparam int DEFAULT_BURST = 4;

   // OWNi: requester i won the previous cycle and is the current owner.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_e;

endpackage : ram_ctrl_pkg

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Arbitrates two request ports onto one external single-port RAM with a
// registered read port. One request is accepted per cycle. The current owner
// keeps the port for up to BURST consecutive accepts while the other side
// waits. The accepted command is registered onto the RAM pins one cycle later.
// A read response returns two cycles after its accept, on the requester that
// issued it.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid[1:0]          per-requester request valid
//   req_ready[1:0]          per-requester accept (one-hot or zero)
//   req_we[1:0]             per-requester op: 1 = write, 0 = read
//   req_addr0/1, req_wdata0/1   request address and write data
//   rsp_valid[1:0]          one-cycle read-response strobe per requester
//   rsp_rdata               read data (qualify with rsp_valid)
//   ram_write_enable, ram_read_enable, ram_address, ram_data_in   RAM command
//   ram_data_out            registered RAM read data
// ---------------------------------------------------------------------------
module ram_arbiter
   import ram_ctrl_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   parameter  int DEPTH = DEFAULT_DEPTH,
   parameter  int BURST = DEFAULT_BURST,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [1:0]       req_we,
   input  logic [AW-1:0]    req_addr0,
   input  logic [AW-1:0]    req_addr1,
   input  logic [WIDTH-1:0] req_wdata0,
   input  logic [WIDTH-1:0] req_wdata1,
   output logic [1:0]       rsp_valid,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             ram_write_enable,
   output logic             ram_read_enable,
   output logic [AW-1:0]    ram_address,
   output logic [WIDTH-1:0] ram_data_in,
   input  logic [WIDTH-1:0] ram_data_out
);

   // Counter must be able to hold BURST itself.
   localparam int            CW      = $clog2(BURST + 1);
   localparam logic [CW-1:0] BURST_C = CW'(BURST);

   // ------------------------------------------------------------------
   // Arbiter state
   // ------------------------------------------------------------------
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          last_q,  last_d;

   logic [1:0]    grant;
   logic          xfer;
   logic          xfer_id;

   // State register.
   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b1;   // requester 0 wins the first contention
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   // Output decode: grant selection, a pure function of state, cnt, last and
   // req_valid. Forced low in reset so nothing is accepted while held.
   // NOTE: every combinational output gets a default first, so no path through
   // the case leaves it unassigned and no latch is inferred.
   always_comb begin
      grant = 2'b00;
      if (rst_n) begin
         case (state_q)
            IDLE: begin
               if (&req_valid) grant = last_q ? 2'b01 : 2'b10;
               else            grant = req_valid;
            end
            OWN0: begin
               if (req_valid[0] && (cnt_q < BURST_C || !req_valid[1])) grant = 2'b01;
               else if (req_valid[1])                                 grant = 2'b10;
            end
            OWN1: begin
               if (req_valid[1] && (cnt_q < BURST_C || !req_valid[0])) grant = 2'b10;
               else if (req_valid[0])                                 grant = 2'b01;
            end
            default: grant = 2'b00;
         endcase
      end
   end

   assign req_ready = grant;
   assign xfer      = |grant;
   assign xfer_id   = grant[1];

   // Next-state logic.
   always_comb begin
      state_d = IDLE;
      cnt_d   = '0;
      last_d  = last_q;
      if (xfer) begin
         state_d = xfer_id ? OWN1 : OWN0;
         last_d  = xfer_id;
         if (state_q == state_d) begin
            // Same owner again: count the run, saturating at BURST.
            cnt_d = (cnt_q == BURST_C) ? cnt_q : cnt_q + CW'(1);
         end else begin
            cnt_d = CW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Command register towards the RAM
   // ------------------------------------------------------------------
   logic             sel_we;
   logic [AW-1:0]    sel_addr;
   logic [WIDTH-1:0] sel_wdata;

   assign sel_we    = req_we[xfer_id];
   assign sel_addr  = xfer_id ? req_addr1  : req_addr0;
   assign sel_wdata = xfer_id ? req_wdata1 : req_wdata0;

   logic             ram_we_q, ram_re_q;
   logic [AW-1:0]    ram_addr_q;
   logic [WIDTH-1:0] ram_din_q;

   // NOTE: the RAM array itself lives outside and is never reset; only the
   // command and tag registers are, so a reset can never fire a stray strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_we_q   <= 1'b0;
         ram_re_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
      end else begin
         ram_we_q <= xfer &  sel_we;
         ram_re_q <= xfer & ~sel_we;
         // Address and data hold their last values on idle cycles.
         if (xfer) begin
            ram_addr_q <= sel_addr;
            ram_din_q  <= sel_wdata;
         end
      end
   end

   assign ram_write_enable = ram_we_q;
   assign ram_read_enable  = ram_re_q;
   assign ram_address      = ram_addr_q;
   assign ram_data_in      = ram_din_q;

   // ------------------------------------------------------------------
   // Response routing: a two-stage tag pipeline that tracks each read from
   // accept (stage 1 = command on the RAM pins) to RAM data valid (stage 2).
   // ------------------------------------------------------------------
   logic tag1_valid_q, tag1_id_q;
   logic tag2_valid_q, tag2_id_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag1_valid_q <= 1'b0;
         tag1_id_q    <= 1'b0;
         tag2_valid_q <= 1'b0;
         tag2_id_q    <= 1'b0;
      end else begin
         tag1_valid_q <= xfer & ~sel_we;
         tag1_id_q    <= xfer_id;
         tag2_valid_q <= tag1_valid_q;
         tag2_id_q    <= tag1_id_q;
      end
   end

   assign rsp_valid = {tag2_valid_q & tag2_id_q, tag2_valid_q & ~tag2_id_q};
   // Passed through unmasked; consumers qualify with rsp_valid.
   assign rsp_rdata = ram_data_out;

endmodule : ram_arbiter

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; SHALL equal the RAM data width.
REQ-002 Parameter DEPTH, default 16, RAM word count; AW = $clog2(DEPTH) SHALL be the address width.
REQ-003 Parameter BURST, default 4, maximum consecutive accepts per requester while the other is waiting.
REQ-004 clock  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  2  per-requester request valid (bit 0 = requester 0, bit 1 = requester 1).
REQ-007 req_ready  out  2  per-requester accept; at most one bit high per cycle.
REQ-008 req_we  in  2  per-requester op: 1 = write, 0 = read.
REQ-009 req_addr0, req_addr1  in  AW each  request addresses.
REQ-010 req_wdata0, req_wdata1  in  WIDTH each  write data.
REQ-011 rsp_valid  out  2  per-requester read-response strobe, one cycle.
REQ-012 rsp_rdata  out  WIDTH  read data, shared; meaningful only when a rsp_valid bit is high.
REQ-013 ram_write_enable, ram_read_enable  out  1 each  RAM strobes; never both high.
REQ-014 ram_address  out  AW;  ram_data_in  out  WIDTH;  RAM command fields.
REQ-015 ram_data_out  in  WIDTH  RAM registered read data.

Function
REQ-016 A transfer SHALL occur on requester i in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-017 req_ready SHALL be combinational from state, cnt, last and req_valid; req_ready[i] SHALL be low unless req_valid[i] is high.
REQ-018 FSM states: IDLE, OWN0, OWN1; the owner is i in state OWNi.
REQ-019 Selection in OWNi: pick i if req_valid[i] and (cnt < BURST or !req_valid[1-i]); else pick 1-i if req_valid[1-i]; else pick none.
REQ-020 Selection in IDLE: if both requesters are valid, pick 1-last; if one is valid, pick it; else pick none.
REQ-021 On a transfer by i: next state = OWNi; last = i; cnt = cnt+1 if i was the owner, else cnt = 1.
REQ-022 On no transfer: next state = IDLE and cnt = 0; last is unchanged.
REQ-023 cnt SHALL be a counter wide enough for BURST and SHALL never exceed BURST.
REQ-024 In the cycle after a transfer, the RAM command SHALL be registered from the transfer: ram_address, ram_data_in = req_wdata, ram_write_enable = we, ram_read_enable = !we.
REQ-025 With no transfer, both strobes SHALL be 0; ram_address and ram_data_in SHALL hold their last values.
REQ-026 Read latency SHALL be exactly 2 cycles: accept in cycle T gives rsp_valid[i] high in T+2 only, with rsp_rdata = ram_data_out.
REQ-027 A 2-stage requester-tag pipeline SHALL route each response; writes SHALL produce no response.
REQ-028 Back-to-back accepts (one per cycle, mixed requesters) SHALL be sustained with no bubbles.
REQ-029 A read issued the cycle after a write to the same address SHALL return the new data, because RAM ordering holds.
REQ-030 rsp_rdata SHALL be driven from ram_data_out without X-masking; consumers SHALL qualify it with rsp_valid.

Reset
REQ-031 While reset is low, the following SHALL hold asynchronously: state = IDLE, cnt = 0, last = 1, ram strobes = 0, ram_address = 0, ram_data_in = 0, rsp_valid = 0, tag pipeline cleared.
REQ-032 With last = 1 at reset, requester 0 SHALL win the first contention.
REQ-033 Reads in flight at reset assertion SHALL be dropped, with no rsp_valid after release.
REQ-034 req_ready SHALL be 0 during reset.

Structure
REQ-035 Shared package ram_ctrl_pkg SHALL hold the default WIDTH/DEPTH/BURST constants and the FSM state enum (IDLE, OWN0, OWN1).
REQ-036 No sub-module is required; ram_arbiter SHALL drive an externally instantiated single-port RAM.

Verification
REQ-037 Scenario: reset release, req0 write addr 3 data 0xA5, then req0 read addr 3 -> ram_write_enable high for 1 cycle, then rsp_valid[0] 2 cycles after the read accept with rsp_rdata = 0xA5.
REQ-038 Scenario: both requesters hold valid reads for 12 cycles, BURST = 4 -> grant pattern 0,0,0,0,1,1,1,1,0,0,0,0, one accept per cycle.
REQ-039 Scenario: only req1 is valid for 10 cycles -> 10 consecutive accepts, cnt saturates at 4, and there is no switch or stall.
REQ-040 Scenario: req0 write addr 7 = 0x3C, req1 read addr 7 on the next cycle -> rsp_valid[1] with 0x3C and rsp_valid[0] never high.
REQ-041 Scenario: reset asserted 1 cycle after a read accept -> rsp_valid stays 0 and ram strobes go 0 immediately.
REQ-042 Scenario: both idle, then both valid, with last = 0 -> req_ready = 2'b10 on the first cycle.
